pll_phase_ctrl: RTL and testbench

//  Request-driven sequencer for the Cyclone III PLL dynamic phase-shift port.

---
 rtl/pll_phase_pkg.sv | 26 ++
 rtl/pll_scanclk_gen.sv | 51 +++++
 rtl/pll_phase_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_pll_phase_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_phase_pkg.sv
// Shared types and constants for the PLL dynamic phase-shift sequencer.
package pll_phase_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPllRst,
    StSetup,
    StAssert,
    StWaitDone,
    StFinish
  } state_e;

  localparam logic [2:0] SEL_ALL = 3'b000;
  localparam logic [2:0] SEL_M   = 3'b001;
  localparam logic [2:0] SEL_C0  = 3'b010;
  localparam logic [2:0] SEL_C1  = 3'b011;
  localparam logic [2:0] SEL_C2  = 3'b100;
  localparam logic [2:0] SEL_C3  = 3'b101;
  localparam logic [2:0] SEL_C4  = 3'b110;

  localparam int unsigned DEF_SCAN_DIV     = 8;
  localparam int unsigned DEF_STEP_HOLD    = 2;
  localparam int unsigned DEF_DONE_TIMEOUT = 100;
  localparam int unsigned DEF_ARESET_CYC   = 16;

endpackage

// File: rtl/pll_scanclk_gen.sv
// scanclk divider: scanclk = clk/(2*SCAN_DIV) while enabled, parked low otherwise.
// rise_tick/fall_tick flag the clk cycle whose edge makes scanclk rise/fall.
module pll_scanclk_gen
  import pll_phase_pkg::*;
#(
  parameter int unsigned SCAN_DIV = DEF_SCAN_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic scanclk,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            wrap;

  always_comb begin
    wrap   = (cnt_q == CntW'(SCAN_DIV - 1));
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    if (!en) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (wrap) begin
      cnt_d  = '0;
      sclk_d = ~sclk_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign rise_tick = en && wrap && !sclk_q;
  assign fall_tick = en && wrap && sclk_q;
  assign scanclk   = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

endmodule

// File: rtl/pll_phase_ctrl.sv
// Command sequencer for the PLL dynamic phase-shift port (areset, N phase steps).
// Define PLL_PHASE_TRACK_EN to add the signed phase_pos accumulator for sel==000 steps.
module pll_phase_ctrl
  import pll_phase_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = DEF_SCAN_DIV,
  parameter int unsigned STEP_HOLD    = DEF_STEP_HOLD,
  parameter int unsigned DONE_TIMEOUT = DEF_DONE_TIMEOUT,
  parameter int unsigned ARESET_CYC   = DEF_ARESET_CYC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_areset,
  input  logic [2:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_steps,
  output logic        busy,
  output logic        cmd_done,
  output logic        cmd_err,
  input  logic        phase_done,
  output logic        areset,
  output logic [2:0]  phasecounterselect,
  output logic        phaseupdown,
  output logic        phasestep,
`ifdef PLL_PHASE_TRACK_EN
  output logic signed [15:0] phase_pos,
`endif
  output logic        scanclk
);

  localparam int unsigned HoldW = $clog2(STEP_HOLD + 1);
  localparam int unsigned ToW   = $clog2(DONE_TIMEOUT + 1);
  localparam int unsigned ArW   = $clog2(ARESET_CYC + 1);

  state_e           state_q, state_d;
  logic [7:0]       steps_q, steps_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [ToW-1:0]   to_q, to_d;
  logic [ArW-1:0]   ar_q, ar_d;
  logic             seen_low_q, seen_low_d;
  logic             done_meta_q, done_sync_q;
  logic             areset_q, areset_d;
  logic             pstep_q, pstep_d;
  logic [2:0]       sel_q, sel_d;
  logic             dir_q, dir_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             sclk_en, rise_tick, fall_tick;
`ifdef PLL_PHASE_TRACK_EN
  logic signed [15:0] pos_q, pos_d;
`endif

  assign sclk_en = (state_q == StSetup) || (state_q == StAssert) || (state_q == StWaitDone);

  pll_scanclk_gen #(
    .SCAN_DIV(SCAN_DIV)
  ) u_scanclk_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (sclk_en),
    .scanclk  (scanclk),
    .rise_tick(rise_tick),
    .fall_tick(fall_tick)
  );

  always_comb begin
    state_d    = state_q;
    steps_d    = steps_q;
    hold_d     = hold_q;
    to_d       = to_q;
    ar_d       = ar_q;
    areset_d   = areset_q;
    pstep_d    = pstep_q;
    sel_d      = sel_q;
    dir_d      = dir_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    err_d      = err_q;
    // A step only counts after phase_done has been observed low since phasestep rose.
    seen_low_d = seen_low_q | ~done_sync_q;
`ifdef PLL_PHASE_TRACK_EN
    pos_d      = pos_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          busy_d = 1'b1;
          err_d  = 1'b0;
          if (req_areset) begin
            areset_d = 1'b1;
            ar_d     = '0;
            state_d  = StPllRst;
          end else begin
            sel_d   = req_sel;
            dir_d   = req_dir;
            steps_d = req_steps;
            state_d = (req_steps == 8'd0) ? StFinish : StSetup;
          end
        end
      end
      StPllRst: begin
        if (ar_q == ArW'(ARESET_CYC - 1)) begin
          areset_d = 1'b0;
          state_d  = StFinish;
`ifdef PLL_PHASE_TRACK_EN
          pos_d    = '0;
`endif
        end else begin
          ar_d = ar_q + 1'b1;
        end
      end
      StSetup: begin
        if (fall_tick) begin
          pstep_d    = 1'b1;
          hold_d     = '0;
          seen_low_d = 1'b0;
          state_d    = StAssert;
        end
      end
      StAssert: begin
        if (!pstep_q) begin
          if (fall_tick) begin
            pstep_d    = 1'b1;
            hold_d     = '0;
            seen_low_d = 1'b0;
          end
        end else begin
          if (rise_tick && (hold_q != HoldW'(STEP_HOLD))) hold_d = hold_q + 1'b1;
          if (fall_tick && (hold_q == HoldW'(STEP_HOLD))) begin
            pstep_d = 1'b0;
            to_d    = '0;
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (seen_low_q && done_sync_q) begin
          steps_d = (steps_q != 8'd0) ? steps_q - 8'd1 : 8'd0;
          state_d = (steps_q <= 8'd1) ? StFinish : StAssert;
`ifdef PLL_PHASE_TRACK_EN
          if (sel_q == SEL_ALL) pos_d = dir_q ? pos_q + 16'sd1 : pos_q - 16'sd1;
`endif
        end else if (rise_tick) begin
          if (to_q == ToW'(DONE_TIMEOUT - 1)) begin
            err_d   = 1'b1;
            steps_d = 8'd0;
            state_d = StFinish;
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      StFinish: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      steps_q     <= '0;
      hold_q      <= '0;
      to_q        <= '0;
      ar_q        <= '0;
      seen_low_q  <= 1'b0;
      done_meta_q <= 1'b0;
      done_sync_q <= 1'b0;
      areset_q    <= 1'b0;
      pstep_q     <= 1'b0;
      sel_q       <= 3'b000;
      dir_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef PLL_PHASE_TRACK_EN
      pos_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      steps_q     <= steps_d;
      hold_q      <= hold_d;
      to_q        <= to_d;
      ar_q        <= ar_d;
      seen_low_q  <= seen_low_d;
      done_meta_q <= phase_done;
      done_sync_q <= done_meta_q;
      areset_q    <= areset_d;
      pstep_q     <= pstep_d;
      sel_q       <= sel_d;
      dir_q       <= dir_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef PLL_PHASE_TRACK_EN
      pos_q       <= pos_d;
`endif
    end
  end

  assign req_ready          = (state_q == StIdle);
  assign busy               = busy_q;
  assign cmd_done           = done_q;
  assign cmd_err            = err_q;
  assign areset             = areset_q;
  assign phasecounterselect = sel_q;
  assign phaseupdown        = dir_q;
  assign phasestep          = pstep_q;
`ifdef PLL_PHASE_TRACK_EN
  assign phase_pos          = pos_q;
`endif

endmodule

// File: tb/tb_pll_phase_ctrl.sv
// Scoreboard bench for pll_phase_ctrl: stimulus queues expected per-command results,
// a negedge monitor accumulates observed activity and compares on every cmd_done.
module tb_pll_phase_ctrl;
  import pll_phase_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_areset = 1'b0, req_dir = 1'b0;
  logic [2:0] req_sel = 3'b000;
  logic [7:0] req_steps = 8'd0;
  logic       phase_done = 1'b1;
  logic       req_ready, busy, cmd_done, cmd_err, areset, phaseupdown, phasestep, scanclk;
  logic [2:0] phasecounterselect;
`ifdef PLL_PHASE_TRACK_EN
  logic signed [15:0] phase_pos;
`endif

  pll_phase_ctrl dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .req_valid         (req_valid),
    .req_ready         (req_ready),
    .req_areset        (req_areset),
    .req_sel           (req_sel),
    .req_dir           (req_dir),
    .req_steps         (req_steps),
    .busy              (busy),
    .cmd_done          (cmd_done),
    .cmd_err           (cmd_err),
    .phase_done        (phase_done),
    .areset            (areset),
    .phasecounterselect(phasecounterselect),
    .phaseupdown       (phaseupdown),
    .phasestep         (phasestep),
`ifdef PLL_PHASE_TRACK_EN
    .phase_pos         (phase_pos),
`endif
    .scanclk           (scanclk)
  );

  always #10 clk = ~clk;

  typedef struct {
    bit         err;
    int         pulses;
    int         ar_cyc;
    bit         chk_sel;
    logic [2:0] sel;
    bit         dir;
    bit         chk_noclk;
    bit         chk_to;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass = 0;
  bit   model_en = 1'b0;

  task automatic check(input string name, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", name, act, req);
  endtask

  task automatic push(input bit err, input int pulses, input int ar_cyc, input bit chk_sel,
                      input logic [2:0] sel, input bit dir, input bit noclk, input bit to);
    exp_t e;
    e.err = err; e.pulses = pulses; e.ar_cyc = ar_cyc; e.chk_sel = chk_sel;
    e.sel = sel; e.dir = dir; e.chk_noclk = noclk; e.chk_to = to;
    exp_q.push_back(e);
  endtask

  // PLL model: phase_done drops 2 scanclk rises after phasestep, returns one rise later.
  initial begin
    forever begin
      @(posedge phasestep);
      if (model_en) begin
        repeat (2) @(posedge scanclk);
        phase_done = 1'b0;
        @(posedge scanclk);
        phase_done = 1'b1;
      end
    end
  end

  // Monitor
  logic sc_prev = 1'b0, ps_prev = 1'b0;
  int   pulses = 0, hold = 0, hold_bad = 0, ar_cyc = 0, sc_tog = 0, rises_after = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pulses = 0; hold = 0; hold_bad = 0; ar_cyc = 0; sc_tog = 0; rises_after = 0;
      sc_prev = 1'b0; ps_prev = 1'b0;
    end else begin
      if (scanclk != sc_prev) sc_tog++;
      if (scanclk && !sc_prev) begin
        if (phasestep) hold++;
        else rises_after++;
      end
      if (phasestep && !ps_prev) begin
        pulses++;
        hold = 0;
      end
      if (!phasestep && ps_prev) begin
        if (hold != 2) hold_bad++;
        rises_after = 0;
      end
      if (areset) ar_cyc++;
      if (cmd_done) begin
        check("cmd_done_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("cmd_err", int'(cmd_err), int'(e.err));
          check("phasestep_pulses", pulses, e.pulses);
          check("areset_cycles", ar_cyc, e.ar_cyc);
          check("step_hold_bad", hold_bad, 0);
          check("busy_at_done", int'(busy), 0);
          if (e.chk_sel) begin
            check("phasecounterselect", int'(phasecounterselect), int'(e.sel));
            check("phaseupdown", int'(phaseupdown), int'(e.dir));
          end
          if (e.chk_noclk) check("scanclk_toggles", sc_tog, 0);
          if (e.chk_to) check("timeout_rises", rises_after, 100);
        end
        pulses = 0; hold = 0; hold_bad = 0; ar_cyc = 0; sc_tog = 0; rises_after = 0;
      end
      sc_prev = scanclk;
      ps_prev = phasestep;
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("ready_within_budget", int'(req_ready), 1);
  endtask

  // Returns #1 after the accepting edge; req_* are then scrambled to show they are ignored.
  task automatic issue(input bit ar, input logic [2:0] sel, input bit dir, input int steps);
    wait_ready();
    req_valid = 1'b1; req_areset = ar; req_sel = sel; req_dir = dir; req_steps = steps[7:0];
    @(posedge clk);
    #1;
    req_valid = 1'b0; req_areset = 1'b0; req_sel = ~sel; req_dir = ~dir; req_steps = 8'hff;
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_areset", int'(areset), 0);
    check("rst_phasestep", int'(phasestep), 0);
    check("rst_scanclk", int'(scanclk), 0);
    check("rst_phaseupdown", int'(phaseupdown), 1);
    check("rst_sel", int'(phasecounterselect), 0);
    check("rst_cmd_done", int'(cmd_done), 0);
    check("rst_cmd_err", int'(cmd_err), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset in the middle of a phasestep pulse
    model_en = 1'b0;
    issue(1'b0, SEL_M, 1'b0, 3);
    n = 0;
    while (!phasestep && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("t1_phasestep_seen", int'(phasestep), 1);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t1_phasestep_async", int'(phasestep), 0);
    check("t1_scanclk_async", int'(scanclk), 0);
    check("t1_busy_async", int'(busy), 0);
    check("t1_phaseupdown_async", int'(phaseupdown), 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("t1_idle_after", int'(req_ready), 1);

    // Three steps up on C0 with a well-behaved PLL
    model_en = 1'b1;
    push(1'b0, 3, 0, 1'b1, SEL_C0, 1'b1, 1'b0, 1'b0);
    issue(1'b0, SEL_C0, 1'b1, 3);
    wait_ready();

    // Zero steps: immediate completion
    push(1'b0, 0, 0, 1'b1, SEL_C3, 1'b0, 1'b1, 1'b0);
    issue(1'b0, SEL_C3, 1'b0, 0);
    check("t3_busy_c1", int'(busy), 1);
    check("t3_no_done_c1", int'(cmd_done), 0);
    @(posedge clk);
    #1;
    check("t3_busy_c2", int'(busy), 0);
    check("t3_done_c2", int'(cmd_done), 1);
    check("t3_ready_c2", int'(req_ready), 1);
    wait_ready();

    // PLL reset command
    push(1'b0, 0, 16, 1'b0, SEL_ALL, 1'b0, 1'b0, 1'b0);
    issue(1'b1, SEL_C1, 1'b1, 7);
    check("t4_areset_rise", int'(areset), 1);
    wait_ready();

`ifdef PLL_PHASE_TRACK_EN
    push(1'b0, 4, 0, 1'b1, SEL_ALL, 1'b1, 1'b0, 1'b0);
    issue(1'b0, SEL_ALL, 1'b1, 4);
    wait_ready();
    push(1'b0, 6, 0, 1'b1, SEL_ALL, 1'b0, 1'b0, 1'b0);
    issue(1'b0, SEL_ALL, 1'b0, 6);
    wait_ready();
    check("t6_pos_after_all", int'(phase_pos), -2);
    push(1'b0, 1, 0, 1'b1, SEL_C1, 1'b1, 1'b0, 1'b0);
    issue(1'b0, SEL_C1, 1'b1, 1);
    wait_ready();
    check("t6_pos_after_c1", int'(phase_pos), -2);
    push(1'b0, 0, 16, 1'b0, SEL_ALL, 1'b0, 1'b0, 1'b0);
    issue(1'b1, SEL_ALL, 1'b0, 0);
    wait_ready();
    check("t6_pos_after_pllrst", int'(phase_pos), 0);
`endif

    // phase_done stuck high: timeout after the first pulse
    model_en = 1'b0;
    phase_done = 1'b1;
    push(1'b1, 1, 0, 1'b1, SEL_C2, 1'b1, 1'b0, 1'b1);
    issue(1'b0, SEL_C2, 1'b1, 5);
    wait_ready();
    repeat (3) @(negedge clk);
    check("t5_err_sticky", int'(cmd_err), 1);
    push(1'b0, 0, 0, 1'b1, SEL_M, 1'b1, 1'b1, 1'b0);
    issue(1'b0, SEL_M, 1'b1, 0);
    check("t5_err_cleared", int'(cmd_err), 0);
    wait_ready();

    repeat (5) @(negedge clk);
    check("scoreboard_drained", int'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

endmodule
